immediate_sequencer: RTL and testbench

- Controller in front of the 4/8/11-bit immediate sign extenders in the decode stage.
- Selects the immediate field for each accepted instruction and sign-extends it to 16 bits.
- Sequences an optional prefix instruction that supplies the upper immediate bits for the next immediate-bearing instruction.
- Presents the result to execute through a registered valid/ready output.

---
 rtl/immediate_sequencer.sv | 140 ++++++++++++++
 tb/tb_immediate_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/immediate_sequencer.sv
// Decode-stage immediate sequencer: picks the imm4/imm8/imm11 field, sign-extends it to 16 bits
// and merges an optional prefix payload. Optional zero-extension is enabled by IMM_ZERO_EXTEND_EN.
module immediate_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InstrValid,
  output logic             InstrReady,
  input  logic [15:0]      Instr,
  input  logic [1:0]       Format,
  input  logic             IsPrefix,
  input  logic             Flush,
  output logic             ImmValid,
  input  logic             ImmReady,
  output logic [WIDTH-1:0] Imm,
  output logic             ImmFromPrefix,
  output logic             PrefixPending,
  output logic             PrefixError
`ifdef IMM_ZERO_EXTEND_EN
  ,
  input  logic             ZeroExt
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_PREF = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [11:0]      prefix_q, prefix_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             fp_q, fp_d;
  logic             vld_q, vld_d;
  logic             perr_q, perr_d;

  logic             zext;
  logic             accept;
  logic             has_imm;
  logic             fill;
  logic [WIDTH-1:0] imm_plain;
  logic [WIDTH-1:0] imm_pref;
  logic             unused_instr_hi;

`ifdef IMM_ZERO_EXTEND_EN
  assign zext = ZeroExt;
`else
  assign zext = 1'b0;
`endif

  assign InstrReady      = !vld_q | ImmReady;
  assign accept          = InstrValid & InstrReady & !Flush;
  assign has_imm         = (Format != 2'b00);
  assign unused_instr_hi = ^Instr[15:12];

  // Fill bit for the un-prefixed path: the field's sign bit unless zero-extension is requested.
  always_comb begin
    fill = 1'b0;
    case (Format)
      2'b01:   fill = Instr[3]  & ~zext;
      2'b10:   fill = Instr[7]  & ~zext;
      2'b11:   fill = Instr[10] & ~zext;
      default: fill = 1'b0;
    endcase
  end

  always_comb begin
    imm_plain = '0;
    case (Format)
      2'b01:   imm_plain = {{(WIDTH-4){fill}},  Instr[3:0]};
      2'b10:   imm_plain = {{(WIDTH-8){fill}},  Instr[7:0]};
      2'b11:   imm_plain = {{(WIDTH-11){fill}}, Instr[10:0]};
      default: imm_plain = '0;
    endcase
  end

  // Prefix supplies exactly the bits above the field; WIDTH is fixed at 16 for this path.
  always_comb begin
    imm_pref = '0;
    case (Format)
      2'b01:   imm_pref = {prefix_q,      Instr[3:0]};
      2'b10:   imm_pref = {prefix_q[7:0], Instr[7:0]};
      2'b11:   imm_pref = {prefix_q[4:0], Instr[10:0]};
      default: imm_pref = '0;
    endcase
  end

  // State register and output registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      prefix_q <= '0;
      imm_q    <= '0;
      fp_q     <= 1'b0;
      vld_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      imm_q    <= imm_d;
      fp_q     <= fp_d;
      vld_q    <= vld_d;
      perr_q   <= perr_d;
    end
  end

  // Next-state: any accepted non-prefix instruction returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (Flush)
      state_d = S_IDLE;
    else if (accept)
      state_d = IsPrefix ? S_PREF : S_IDLE;
  end

  // Output / datapath next values
  always_comb begin
    prefix_d = prefix_q;
    imm_d    = imm_q;
    fp_d     = fp_q;
    vld_d    = vld_q & ~ImmReady;
    perr_d   = accept & (state_q == S_PREF) & (IsPrefix | ~has_imm);

    if (accept && IsPrefix)
      prefix_d = Instr[11:0];

    if (Flush) begin
      vld_d = 1'b0;
    end else if (accept && !IsPrefix && has_imm) begin
      vld_d = 1'b1;
      imm_d = (state_q == S_PREF) ? imm_pref : imm_plain;
      fp_d  = (state_q == S_PREF);
    end
  end

  assign ImmValid      = vld_q;
  assign Imm           = imm_q;
  assign ImmFromPrefix = fp_q;
  assign PrefixPending = (state_q == S_PREF);
  assign PrefixError   = perr_q;

endmodule

// File: tb/tb_immediate_sequencer.sv
// Bench for immediate_sequencer: directed cases plus randomized traffic against an arithmetic
// model of immediate construction and prefix sequencing.
module tb_immediate_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, InstrValid, InstrReady, IsPrefix, Flush;
  logic        ImmValid, ImmReady, ImmFromPrefix, PrefixPending, PrefixError;
  logic [15:0] Instr, Imm;
  logic [1:0]  Format;
  logic        zext;

  always #5 Clk = ~Clk;

  immediate_sequencer #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .Format(Format), .IsPrefix(IsPrefix), .Flush(Flush),
    .ImmValid(ImmValid), .ImmReady(ImmReady), .Imm(Imm),
    .ImmFromPrefix(ImmFromPrefix), .PrefixPending(PrefixPending), .PrefixError(PrefixError)
`ifdef IMM_ZERO_EXTEND_EN
    , .ZeroExt(zext)
`endif
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state: output register contents, whether a prefix is held, its payload.
  bit m_vld, m_fp, m_pend, m_perr;
  int m_imm, m_p;

  function automatic int ref_imm(int fmt, int instr, bit pend, int p, bit zx);
    int bits, field;
    bits  = (fmt == 1) ? 4 : (fmt == 2) ? 8 : 11;
    field = instr % (1 << bits);
    if (pend)                          return (p * (1 << bits) + field) % 65536;
    if (zx)                            return field;
    if (field >= (1 << (bits - 1)))    return field + 65536 - (1 << bits);
    return field;
  endfunction

  task automatic step(input bit rst, input bit iv, input bit isp, input int fmt, input int instr,
                      input bit rdy, input bit fl, input bit zx);
    bit acc;
    @(negedge Clk);
    Reset = ~rst; InstrValid = iv; IsPrefix = isp; Format = fmt[1:0]; Instr = instr[15:0];
    ImmReady = rdy; Flush = fl; zext = zx;
    #1;
    chk("InstrReady", {31'd0, InstrReady}, {31'd0, (!m_vld || rdy)});
    if (rst) begin
      m_vld = 0; m_fp = 0; m_pend = 0; m_perr = 0; m_imm = 0; m_p = 0;
    end else if (fl) begin
      m_vld = 0; m_pend = 0; m_perr = 0;
    end else begin
      acc    = iv && (!m_vld || rdy);
      m_perr = 0;
      if (m_vld && rdy) m_vld = 0;
      if (acc) begin
        if (isp) begin
          m_perr = m_pend;
          m_pend = 1;
          m_p    = instr % 4096;
        end else if (fmt == 0) begin
          m_perr = m_pend;
          m_pend = 0;
        end else begin
          m_imm  = ref_imm(fmt, instr, m_pend, m_p, zx);
          m_fp   = m_pend;
          m_vld  = 1;
          m_pend = 0;
        end
      end
    end
    @(posedge Clk);
    #1;
    chk("ImmValid", {31'd0, ImmValid}, {31'd0, m_vld});
    if (m_vld) begin
      chk("Imm", {16'd0, Imm}, m_imm);
      chk("ImmFromPrefix", {31'd0, ImmFromPrefix}, {31'd0, m_fp});
    end
    chk("PrefixPending", {31'd0, PrefixPending}, {31'd0, m_pend});
    chk("PrefixError", {31'd0, PrefixError}, {31'd0, m_perr});
  endtask

  bit zx_r;
  int perr_cnt;

  initial begin
    Reset = 0; InstrValid = 0; IsPrefix = 0; Format = 0; Instr = 0;
    ImmReady = 0; Flush = 0; zext = 0;

    // Reset held with traffic present
    step(1, 1, 0, 1, 16'h0008, 1, 0, 0);
    step(1, 1, 0, 2, 16'h00FF, 1, 0, 0);
    chk("rst_Imm", {16'd0, Imm}, 32'h0);
    chk("rst_ImmFromPrefix", {31'd0, ImmFromPrefix}, 32'h0);
    chk("rst_InstrReady", {31'd0, InstrReady}, 32'h1);

    // Spot checks
    step(0, 1, 0, 1, 16'h0008, 1, 0, 0); chk("spot_imm4", {16'd0, Imm}, 32'hFFF8);
    step(0, 1, 0, 2, 16'h007F, 1, 0, 0); chk("spot_imm8", {16'd0, Imm}, 32'h007F);
    step(0, 1, 0, 3, 16'h0400, 1, 0, 0); chk("spot_imm11", {16'd0, Imm}, 32'hFC00);

    // Full field sweeps
    for (int i = 0; i < 16; i++)   step(0, 1, 0, 1, i, 1, 0, 0);
    for (int i = 0; i < 256; i++)  step(0, 1, 0, 2, i, 1, 0, 0);
    for (int i = 0; i < 2048; i++) step(0, 1, 0, 3, i, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Prefix with imm4
    step(0, 1, 1, 0, 16'h0ABC, 1, 0, 0); chk("pfx4_pending", {31'd0, PrefixPending}, 32'h1);
    step(0, 1, 0, 1, 16'h0005, 1, 0, 0);
    chk("pfx4_imm", {16'd0, Imm}, 32'hABC5);
    chk("pfx4_from", {31'd0, ImmFromPrefix}, 32'h1);
    chk("pfx4_pending_clr", {31'd0, PrefixPending}, 32'h0);

    // Prefix with imm11
    step(0, 1, 1, 0, 16'h0013, 1, 0, 0);
    step(0, 1, 0, 3, 16'h07FF, 1, 0, 0); chk("pfx11_imm", {16'd0, Imm}, 32'h9FFF);

    // Double prefix: one error pulse, second payload wins
    perr_cnt = 0;
    step(0, 1, 1, 0, 16'h0001, 1, 0, 0); perr_cnt += PrefixError;
    step(0, 1, 1, 0, 16'h0002, 1, 0, 0); perr_cnt += PrefixError;
    step(0, 1, 0, 2, 16'h0034, 1, 0, 0); perr_cnt += PrefixError;
    chk("dblpfx_imm", {16'd0, Imm}, 32'h0234);
    chk("dblpfx_errcnt", perr_cnt, 32'd1);

    // Prefix then format 00
    step(0, 1, 1, 0, 16'h0055, 1, 0, 0);
    step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
    chk("pfx00_err", {31'd0, PrefixError}, 32'h1);
    chk("pfx00_vld", {31'd0, ImmValid}, 32'h0);

    // Backpressure hold
    step(0, 1, 0, 1, 16'h0007, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 2, 16'h0080, 0, 0, 0);
      chk("bp_imm", {16'd0, Imm}, 32'h0007);
      chk("bp_ready", {31'd0, InstrReady}, 32'h0);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Flush with a held prefix
    step(0, 1, 1, 0, 16'h0321, 1, 0, 0);
    step(0, 1, 0, 1, 16'h0003, 1, 1, 0);
    chk("flush_pending", {31'd0, PrefixPending}, 32'h0);
    chk("flush_vld", {31'd0, ImmValid}, 32'h0);
    chk("flush_perr", {31'd0, PrefixError}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      zx_r = 0;
`ifdef IMM_ZERO_EXTEND_EN
      zx_r = $urandom_range(0, 1);
`endif
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 20,
           $urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 4, zx_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
